hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of tracked stages after ID (1=EX, 2=MEM, 3=WB), legal range 2..7.
REQ-002 SHALL have parameter LOAD_STAGE, default 2, first stage whose output carries load data, legal range 2..STAGES.
REQ-003 SHALL have parameter FWD_EN, default 1, enabling forwarding (0 = stall-only mode).
REQ-004 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-005 SHALL define FW = $clog2(STAGES+1) as the forward-select width.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 valid_id  in  1  ID holds a real instruction.
REQ-009 rs1_id, rs2_id  in  5 each  ID source registers.
REQ-010 rs1use, rs2use  in  1 each  ID instruction reads rs1/rs2.
REQ-011 rd_id  in  5  ID destination register.
REQ-012 regwrite_id  in  1  ID instruction writes rd.
REQ-013 load_id  in  1  ID instruction is a load.
REQ-014 redirect_id  in  1  branch/JAL/JALR taken, resolved in ID.
REQ-015 stall  out  1  hold PC and IF/ID; insert bubble into EX.
REQ-016 flush_if  out  1  kill the instruction in IF/ID next cycle.
REQ-017 fwd_sel_a, fwd_sel_b  out  FW each  0 = regfile, k = forward from stage k.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 SHALL keep a scoreboard S[1..STAGES] of {valid, rd, regwrite, load}, and SHALL update it every cycle regardless of stall.
REQ-020 Each cycle S[k] <= S[k-1] for k >= 2; S[1] <= ID info when valid_id & ~stall, else bubble (valid=0).
REQ-021 An entry SHALL match operand rsX when valid & regwrite & rd != 0 & rd == rsX & rsXuse; register x0 never matches.
REQ-022 The winning match per operand SHALL be the smallest k (youngest producer) and SHALL be one-hot priority resolved.
REQ-023 FWD_EN=1: fwd_sel = winning k; a win with load=1 and k < LOAD_STAGE SHALL assert stall.
REQ-024 FWD_EN=0: any win with k < STAGES SHALL assert stall; fwd_sel SHALL be 0 always; k = STAGES relies on regfile write-through.
REQ-025 No match, or valid_id=0: fwd_sel = 0, no stall from that operand.
REQ-026 stall, flush_if and fwd_sel SHALL be combinational from the ID inputs and the scoreboard (zero-cycle latency).
REQ-027 flush_if = redirect_id & valid_id & ~stall; stall has priority, so a redirect under stall is ignored and is re-presented by ID the next cycle.
REQ-028 stall_cnt SHALL increment on each stalled cycle and flush_cnt on each flush_if cycle; both SHALL saturate at all-ones without wrapping.
REQ-029 A load-use hazard SHALL stall for exactly LOAD_STAGE-1 cycles for an immediately dependent instruction.

Reset
REQ-030 With rst_n=0 at a clock edge: all S[k].valid=0, stall_cnt=0, flush_cnt=0.
REQ-031 Reset mid-stall SHALL clear the stall on the next cycle; outputs remain combinational, so stall=0 and fwd_sel=0 whenever the scoreboard is empty.

Structure
REQ-032 A shared package SHALL hold the scoreboard-entry struct, the fwd_sel encoding constants (FWD_RF=0) and the parameter defaults.
REQ-033 A sub-module hazard_match (one operand against the scoreboard, returns hit, k and is_load) SHALL be instantiated twice.

Verification
REQ-034 ADD x5 followed by ADD x6,x5,x1 -> fwd_sel_a=1, stall=0.
REQ-035 LW x5 followed by dependent ADD -> stall=1 for 1 cycle, then fwd_sel_a=2; stall_cnt=1.
REQ-036 Writes to x0 followed by a reader of x0 -> fwd_sel=0, no stall; rs2use=0 with a matching rs2 -> fwd_sel_b=0.
REQ-037 BEQ taken (redirect_id=1) with no hazard -> flush_if=1, flush_cnt=1; BEQ dependent on the preceding LW -> flush_if=0 during the stall, flush_if=1 on the following cycle.
REQ-038 FWD_EN=0, STAGES=3: ADD x5 followed by dependent ADD -> stall for 2 cycles, fwd_sel_a=0 throughout.
REQ-039 Preload stall_cnt to all-ones, then stall -> counter holds all-ones; assert rst_n=0 mid-stall -> the next cycle shows stall=0 and counters=0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the ID-stage hazard detection and forwarding unit.
package hazard_ctrl_unit_pkg;

  localparam int unsigned STAGES_DEF     = 3;
  localparam int unsigned LOAD_STAGE_DEF = 2;
  localparam bit          FWD_EN_DEF     = 1'b1;
  localparam int unsigned CNT_W_DEF      = 32;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Matches one ID source operand against the in-flight scoreboard; youngest producer wins.
module hazard_match
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned FW     = $clog2(STAGES_DEF + 1)
) (
  input  sb_entry_t [STAGES:1] sb,
  input  logic [4:0]           rs,
  input  logic                 use_rs,
  output logic                 hit,
  output logic [FW-1:0]        k,
  output logic                 is_load
);

  logic [STAGES:1] match;
  logic [STAGES:1] sel;

  always_comb begin
    match = '0;
    for (int unsigned i = 1; i <= STAGES; i++) begin
      match[i] = sb[i].valid & sb[i].regwrite & (sb[i].rd != 5'd0) &
                 (sb[i].rd == rs) & use_rs;
    end
  end

  // One-hot select of the lowest matching stage, then encode from the one-hot vector.
  always_comb begin
    hit     = 1'b0;
    sel     = '0;
    k       = '0;
    is_load = 1'b0;
    for (int unsigned i = 1; i <= STAGES; i++) begin
      if (match[i] && !hit) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
      end
    end
    for (int unsigned i = 1; i <= STAGES; i++) begin
      if (sel[i]) begin
        k       = k | FW'(i);
        is_load = is_load | sb[i].load;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard control: producer scoreboard, forward select, load-use/stall-only stalls,
// redirect flush and saturating event counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned STAGES     = STAGES_DEF,
  parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF,
  parameter bit          FWD_EN     = FWD_EN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  localparam int unsigned FW        = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1use,
  input  logic             rs2use,
  input  logic [4:0]       rd_id,
  input  logic             regwrite_id,
  input  logic             load_id,
  input  logic             redirect_id,
  output logic             stall,
  output logic             flush_if,
  output logic [FW-1:0]    fwd_sel_a,
  output logic [FW-1:0]    fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [FW-1:0] LOAD_K = FW'(LOAD_STAGE);
  localparam logic [FW-1:0] LAST_K = FW'(STAGES);
  localparam logic [FW-1:0] SEL_RF = FW'(FWD_RF);

  sb_entry_t [STAGES:1] sb;

  logic          hit_a, hit_b;
  logic          load_a, load_b;
  logic [FW-1:0] k_a, k_b;
  logic          stall_a, stall_b;

  hazard_match #(.STAGES(STAGES), .FW(FW)) u_match_a (
    .sb      (sb),
    .rs      (rs1_id),
    .use_rs  (rs1use),
    .hit     (hit_a),
    .k       (k_a),
    .is_load (load_a)
  );

  hazard_match #(.STAGES(STAGES), .FW(FW)) u_match_b (
    .sb      (sb),
    .rs      (rs2_id),
    .use_rs  (rs2use),
    .hit     (hit_b),
    .k       (k_b),
    .is_load (load_b)
  );

  // Stall-only mode waits until the producer reaches the last stage (regfile write-through).
  always_comb begin
    stall_a   = 1'b0;
    stall_b   = 1'b0;
    fwd_sel_a = SEL_RF;
    fwd_sel_b = SEL_RF;
    if (FWD_EN) begin
      stall_a = valid_id & hit_a & load_a & (k_a < LOAD_K);
      stall_b = valid_id & hit_b & load_b & (k_b < LOAD_K);
      if (valid_id && hit_a) fwd_sel_a = k_a;
      if (valid_id && hit_b) fwd_sel_b = k_b;
    end else begin
      stall_a = valid_id & hit_a & (k_a < LAST_K);
      stall_b = valid_id & hit_b & (k_b < LAST_K);
    end
    stall    = stall_a | stall_b;
    flush_if = redirect_id & valid_id & ~stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      if (valid_id && !stall) begin
        sb[1] <= '{valid: 1'b1, rd: rd_id, regwrite: regwrite_id, load: load_id};
      end else begin
        sb[1] <= '0;
      end
      for (int unsigned i = 2; i <= STAGES; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: default, stall-only and saturating-counter configurations.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_id;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic       rs1use, rs2use, regwrite_id, load_id, redirect_id;

  logic        st0, fl0, st1, fl1, st2, fl2;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [2:0]  fa2, fb2;
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  int checks = 0;
  int errors = 0;
  int stepn  = 0;

  typedef struct {
    int         dut;
    logic       st;
    logic       fl;
    logic [2:0] fa;
    logic [2:0] fb;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_ctrl_unit u_d0 (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1use(rs1use), .rs2use(rs2use), .rd_id(rd_id), .regwrite_id(regwrite_id),
    .load_id(load_id), .redirect_id(redirect_id), .stall(st0), .flush_if(fl0),
    .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_ctrl_unit #(.STAGES(3), .FWD_EN(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1use(rs1use), .rs2use(rs2use), .rd_id(rd_id), .regwrite_id(regwrite_id),
    .load_id(load_id), .redirect_id(redirect_id), .stall(st1), .flush_if(fl1),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl_unit #(.STAGES(7), .LOAD_STAGE(2), .FWD_EN(1'b0), .CNT_W(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1use(rs1use), .rs2use(rs2use), .rd_id(rd_id), .regwrite_id(regwrite_id),
    .load_id(load_id), .redirect_id(redirect_id), .stall(st2), .flush_if(fl2),
    .fwd_sel_a(fa2), .fwd_sel_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic rdir);
    @(negedge clk);
    valid_id    = v;
    rs1_id      = r1;
    rs1use      = u1;
    rs2_id      = r2;
    rs2use      = u2;
    rd_id       = rd;
    regwrite_id = rw;
    load_id     = ld;
    redirect_id = rdir;
  endtask

  task automatic ins(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic ld);
    drive(1'b1, r1, 1'b1, r2, 1'b1, rd, 1'b1, ld, 1'b0);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic compare_out();
    exp_t e;
    logic       st, fl;
    logic [2:0] fa, fb;
    e = q.pop_front();
    case (e.dut)
      0:       begin st = st0; fl = fl0; fa = {1'b0, fa0}; fb = {1'b0, fb0}; end
      1:       begin st = st1; fl = fl1; fa = {1'b0, fa1}; fb = {1'b0, fb1}; end
      default: begin st = st2; fl = fl2; fa = fa2; fb = fb2; end
    endcase
    chk($sformatf("s%0d_d%0d_stall", stepn, e.dut), 32'(st), 32'(e.st));
    chk($sformatf("s%0d_d%0d_flush", stepn, e.dut), 32'(fl), 32'(e.fl));
    chk($sformatf("s%0d_d%0d_fwd_a", stepn, e.dut), 32'(fa), 32'(e.fa));
    chk($sformatf("s%0d_d%0d_fwd_b", stepn, e.dut), 32'(fb), 32'(e.fb));
  endtask

  task automatic expect_out(input int dut, input logic st, input logic fl,
                            input logic [2:0] fa, input logic [2:0] fb);
    stepn++;
    q.push_back('{dut: dut, st: st, fl: fl, fa: fa, fb: fb});
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_id = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_id = 1'b0; rs1_id = '0; rs2_id = '0; rd_id = '0;
    rs1use = 1'b0; rs2use = 1'b0; regwrite_id = 1'b0; load_id = 1'b0; redirect_id = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sc0", sc0, 32'd0);
    chk("rst_fc0", fc0, 32'd0);
    chk("rst_sc1", sc1, 32'd0);
    chk("rst_sc2", 32'(sc2), 32'd0);
    expect_out(0, 1'b0, 1'b0, 3'd0, 3'd0);
    rst_n = 1'b1;

    // EX forwarding, mixed-stage forwarding on both operands
    ins(5'd5, 5'd1, 5'd2, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd1, 3'd0);
    ins(5'd7, 5'd5, 5'd6, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd2, 3'd1);
    nop(3);
    // WB forwarding
    ins(5'd7, 5'd0, 5'd0, 1'b0);
    nop(2);
    ins(5'd8, 5'd3, 5'd7, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd0, 3'd3);
    nop(3);
    // youngest producer wins
    ins(5'd5, 5'd0, 5'd0, 1'b0);
    ins(5'd5, 5'd0, 5'd0, 1'b0);
    ins(5'd9, 5'd5, 5'd0, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd1, 3'd0);
    nop(3);

    // load-use: one stall cycle, then forward from MEM
    ins(5'd5, 5'd2, 5'd0, 1'b1);
    ins(5'd6, 5'd5, 5'd3, 1'b0);  expect_out(0, 1'b1, 1'b0, 3'd1, 3'd0);
    ins(5'd6, 5'd5, 5'd3, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd2, 3'd0);
    chk("lu_sc0", sc0, 32'd1);
    nop(3);

    // x0 never matches; unused rs2 never forwards
    ins(5'd0, 5'd1, 5'd2, 1'b0);
    ins(5'd6, 5'd0, 5'd0, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd0, 3'd0);
    nop(3);
    ins(5'd0, 5'd1, 5'd2, 1'b1);
    ins(5'd6, 5'd0, 5'd0, 1'b0);  expect_out(0, 1'b0, 1'b0, 3'd0, 3'd0);
    nop(3);
    ins(5'd9, 5'd1, 5'd2, 1'b0);
    drive(1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    expect_out(0, 1'b0, 1'b0, 3'd0, 3'd0);
    nop(3);
    // empty ID slot ignores a matching load
    ins(5'd5, 5'd1, 5'd2, 1'b1);
    drive(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    expect_out(0, 1'b0, 1'b0, 3'd0, 3'd0);
    nop(3);
    chk("x0_sc0", sc0, 32'd1);

    // taken branch without hazard
    drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_out(0, 1'b0, 1'b1, 3'd0, 3'd0);
    nop(1);
    chk("br_fc0", fc0, 32'd1);
    nop(2);
    // taken branch behind a load: flush deferred until the stall clears
    ins(5'd5, 5'd2, 5'd0, 1'b1);
    drive(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_out(0, 1'b1, 1'b0, 3'd1, 3'd0);
    drive(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_out(0, 1'b0, 1'b1, 3'd2, 3'd0);
    nop(1);
    chk("brlu_fc0", fc0, 32'd2);
    chk("brlu_sc0", sc0, 32'd2);

    // stall-only mode: two stall cycles, never forwards
    do_reset();
    ins(5'd5, 5'd1, 5'd2, 1'b0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(1, 1'b1, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(1, 1'b1, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(1, 1'b0, 1'b0, 3'd0, 3'd0);
    chk("so_sc1", sc1, 32'd2);

    // 2-bit counter saturation in a 7-stage stall-only unit, then reset mid-stall
    do_reset();
    ins(5'd5, 5'd1, 5'd2, 1'b0);  expect_out(2, 1'b0, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(2, 1'b1, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(2, 1'b1, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(2, 1'b1, 1'b0, 3'd0, 3'd0);
    chk("sat_sc2_2", 32'(sc2), 32'd2);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(2, 1'b1, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);  expect_out(2, 1'b1, 1'b0, 3'd0, 3'd0);
    chk("sat_sc2_3", 32'(sc2), 32'd3);
    ins(5'd6, 5'd5, 5'd1, 1'b0);
    rst_n = 1'b0;
    expect_out(2, 1'b1, 1'b0, 3'd0, 3'd0);
    ins(5'd6, 5'd5, 5'd1, 1'b0);
    rst_n = 1'b1;
    expect_out(2, 1'b0, 1'b0, 3'd0, 3'd0);
    chk("rstmid_sc2", 32'(sc2), 32'd0);
    chk("rstmid_fc2", 32'(fc2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
